// File: rtl/dpsk_pkg.sv
// dpsk_pkg
// Shared tables and helpers for the DBPSK/DQPSK symbol mapper.
//   - Gray increment tables (DQPSK, DBPSK)
//   - phase-to-sign tables, one sign bit per axis (1 = negative)
//   - signed_amp(): turns a sign bit into +/-AMP
//   - params_legal(): parameter legality check used at elaboration
package dpsk_pkg;

    // DQPSK Gray increment, indexed by {a,b} with a the first bit received.
    // 00 -> 0, 01 -> 1, 10 -> 3, 11 -> 2 (units of 90 degrees).
    localparam logic [1:0] DQPSK_INC [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

    // DBPSK: the bit itself is the increment (units of 180 degrees).
    localparam logic [0:0] DBPSK_INC [2] = '{1'b0, 1'b1};

    // Sign bit per axis, indexed by phase.
    // DQPSK: p0 (+,+), p1 (-,+), p2 (-,-), p3 (+,-).
    localparam logic [3:0] DQPSK_I_NEG = 4'b1001 ^ 4'b1111;
    localparam logic [3:0] DQPSK_Q_NEG = 4'b1100;
    // DBPSK: p0 +, p1 -.
    localparam logic [1:0] DBPSK_I_NEG = 2'b10;

    // Map a sign bit to +/-amp; the caller narrows to its output width.
    function automatic int signed_amp(input logic neg, input int amp);
        return neg ? -amp : amp;
    endfunction

    // Legal when BITS_PER_SYM is 1 or 2, CLKS_PER_BIT >= 2 and
    // 1 <= AMP <= 2^(OUT_W-1)-1.
    function automatic bit params_legal(input int bps, input int cpb,
                                        input int out_w, input int amp);
        return (bps == 1 || bps == 2) && (cpb >= 2) && (out_w >= 2) &&
               (out_w <= 31) && (amp >= 1) && (amp <= (1 << (out_w - 1)) - 1);
    endfunction

endpackage

// File: rtl/dpsk_diff_encoder.sv
// dpsk_diff_encoder
// Phase register for the symbol mapper. On each update strobe the phase
// either accumulates the increment (differential) or is overwritten by it
// (absolute). The register width makes the add wrap modulo 2^BITS_PER_SYM.
// Ports:
//   clk, rst     clock, async active-high reset (phase -> 0)
//   update       enable-qualified strobe, high on the last-bit sample edge
//   diff_en      1 = accumulate, 0 = absolute
//   inc          Gray-decoded phase increment
//   phase        current phase
module dpsk_diff_encoder #(
    parameter int BITS_PER_SYM = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic                    diff_en,
    input  logic [BITS_PER_SYM-1:0] inc,
    output logic [BITS_PER_SYM-1:0] phase
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (update) begin
            phase <= diff_en ? (phase + inc) : inc;
        end
    end

endmodule

// File: rtl/dpsk_symbol_mapper.sv
// dpsk_symbol_mapper
// Serial-to-symbol mapper for the DBPSK/DQPSK transmit chain. Bits are
// sampled once every CLKS_PER_BIT cycles, grouped into symbols, Gray
// decoded into a phase increment and mapped to signed +/-AMP I/Q samples.
// Ports:
//   clk, rst     clock, async active-high reset
//   en           clock enable; low freezes all state
//   din          serial data, sampled when bit_strobe is high
//   diff_en      1 = differential, 0 = absolute mapping (taken per symbol)
//   zero_stuff   1 = value only in the sym_strobe cycle, 0 = hold
//   bit_strobe   high in the cycle din is sampled
//   sym_strobe   high in the first cycle of a new di/dq value
//   di, dq       signed I/Q samples (dq is 0 for DBPSK)
module dpsk_symbol_mapper
    import dpsk_pkg::*;
#(
    parameter int BITS_PER_SYM = 2,
    parameter int CLKS_PER_BIT = 4,
    parameter int OUT_W        = 2,
    parameter int AMP          = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    din,
    input  logic                    diff_en,
    input  logic                    zero_stuff,
    output logic                    bit_strobe,
    output logic                    sym_strobe,
    output logic signed [OUT_W-1:0] di,
    output logic signed [OUT_W-1:0] dq
);

    if (!params_legal(BITS_PER_SYM, CLKS_PER_BIT, OUT_W, AMP)) begin : g_param_error
        $error("dpsk_symbol_mapper: illegal BITS_PER_SYM/CLKS_PER_BIT/OUT_W/AMP");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic IDX_LAST = 1'(BITS_PER_SYM - 1);

    // The symbol cycle counter is split into a per-bit counter and a bit
    // index, so sample points are simply bit_cnt == 0.
    logic [CNT_W-1:0]        bit_cnt;
    logic                    bit_idx;
    logic                    sample;
    logic                    last_sample;
    logic                    pending;
    logic                    zs_mode;
    logic [BITS_PER_SYM-1:0] inc;
    logic [BITS_PER_SYM-1:0] phase;
    logic signed [OUT_W-1:0] i_val;
    logic signed [OUT_W-1:0] q_val;

    assign sample      = (bit_cnt == '0);
    assign last_sample = en && sample && (bit_idx == IDX_LAST);
    // bit_strobe follows en directly so it marks exactly the sampling cycle.
    assign bit_strobe  = en && sample && !rst;

    if (BITS_PER_SYM == 2) begin : g_dqpsk
        // Holds the first bit of the symbol; the second arrives on din at the
        // last-bit edge, so the increment is formed without a second register.
        logic first_bit;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                first_bit <= 1'b0;
            end else if (en && sample && (bit_idx == 1'b0)) begin
                first_bit <= din;
            end
        end

        assign inc   = DQPSK_INC[{first_bit, din}];
        assign i_val = OUT_W'(signed_amp(DQPSK_I_NEG[phase], AMP));
        assign q_val = OUT_W'(signed_amp(DQPSK_Q_NEG[phase], AMP));
    end else begin : g_dbpsk
        assign inc   = DBPSK_INC[din];
        assign i_val = OUT_W'(signed_amp(DBPSK_I_NEG[phase], AMP));
        assign q_val = '0;
    end

    // diff_en is consumed by the encoder on the last-bit edge itself, which
    // is the same edge the mode is defined to be captured on.
    dpsk_diff_encoder #(
        .BITS_PER_SYM(BITS_PER_SYM)
    ) u_diff_encoder (
        .clk     (clk),
        .rst     (rst),
        .update  (last_sample),
        .diff_en (diff_en),
        .inc     (inc),
        .phase   (phase)
    );

    // Bit timer, zero_stuff capture and output registers. The output stage
    // loads one enabled cycle after the phase update (pending), giving the
    // two-cycle sample-to-output latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            bit_idx    <= 1'b0;
            pending    <= 1'b0;
            zs_mode    <= 1'b0;
            sym_strobe <= 1'b0;
            di         <= '0;
            dq         <= '0;
        end else if (en) begin
            if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
                bit_idx <= (bit_idx == IDX_LAST) ? 1'b0 : (bit_idx + 1'b1);
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            pending <= last_sample;
            if (last_sample) begin
                zs_mode <= zero_stuff;
            end
            if (pending) begin
                di         <= i_val;
                dq         <= q_val;
                sym_strobe <= 1'b1;
            end else begin
                sym_strobe <= 1'b0;
                if (zs_mode) begin
                    di <= '0;
                    dq <= '0;
                end
            end
        end else begin
            sym_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dpsk_symbol_mapper.sv
// tb_dpsk_symbol_mapper
// Self-checking bench. Three mapper instances share one stimulus stream:
//   dut 0: defaults (DQPSK, OUT_W=2, AMP=1)
//   dut 1: DQPSK, OUT_W=3, AMP=3
//   dut 2: DBPSK, CLKS_PER_BIT=4
// A constellation-angle reference model checks every output of every
// instance each cycle; directed table vectors and hand sequences add
// targeted checks.
module tb_dpsk_symbol_mapper;

    localparam int CPB = 4;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic din = 1'b0;
    logic diff_en = 1'b0;
    logic zero_stuff = 1'b0;

    logic bs_a, ss_a, bs_b, ss_b, bs_c, ss_c;
    logic signed [1:0] di_a, dq_a, di_c, dq_c;
    logic signed [2:0] di_b, dq_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    typedef struct {
        int cnt;
        int sym;
        int p;
        int di;
        int dq;
        int nd;
        int nq;
        bit ss;
        bit pending;
        bit zs;
    } model_t;

    typedef struct {
        int         dut;
        logic [1:0] bits;
        bit         diff;
        bit         zs;
        int         exp_di;
        int         exp_dq;
    } vec_t;

    model_t mdl [3];
    vec_t   tbl [16];

    always #5 clk = ~clk;

    dpsk_symbol_mapper u_dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .diff_en(diff_en),
        .zero_stuff(zero_stuff), .bit_strobe(bs_a), .sym_strobe(ss_a),
        .di(di_a), .dq(dq_a)
    );

    dpsk_symbol_mapper #(.BITS_PER_SYM(2), .CLKS_PER_BIT(CPB), .OUT_W(3), .AMP(3)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .diff_en(diff_en),
        .zero_stuff(zero_stuff), .bit_strobe(bs_b), .sym_strobe(ss_b),
        .di(di_b), .dq(dq_b)
    );

    dpsk_symbol_mapper #(.BITS_PER_SYM(1), .CLKS_PER_BIT(CPB), .OUT_W(2), .AMP(1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .din(din), .diff_en(diff_en),
        .zero_stuff(zero_stuff), .bit_strobe(bs_c), .sym_strobe(ss_c),
        .di(di_c), .dq(dq_c)
    );

    function automatic int bps_of(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    function automatic int amp_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    // Reference model: bits collected per symbol, Gray decoded with
    // arithmetic, phase tracked as a constellation angle and projected to
    // +/-amp by the sign of cos/sin. New values become visible one enabled
    // cycle after the symbol completes.
    function automatic model_t model_step(input model_t m_in, input int bps, input int amp,
                                          input bit e, input bit b, input bit d, input bit z);
        model_t m;
        int k;
        int inc;
        real deg;
        m = m_in;
        if (!e) begin
            m.ss = 1'b0;
            return m;
        end
        if (m.pending) begin
            m.di = m.nd;
            m.dq = m.nq;
            m.ss = 1'b1;
            m.pending = 1'b0;
        end else begin
            m.ss = 1'b0;
            if (m.zs) begin
                m.di = 0;
                m.dq = 0;
            end
        end
        if (m.cnt % CPB == 0) begin
            k = m.cnt / CPB;
            m.sym = (k == 0) ? int'(b) : m.sym * 2 + int'(b);
            if (k == bps - 1) begin
                inc = (bps == 2) ? (m.sym ^ (m.sym >> 1)) : m.sym;
                m.p = d ? (m.p + inc) % (1 << bps) : inc;
                deg = (bps == 2) ? 45.0 + 90.0 * m.p : 180.0 * m.p;
                m.nd = ($cos(deg * PI / 180.0) > 0.0) ? amp : -amp;
                m.nq = (bps == 2) ? (($sin(deg * PI / 180.0) > 0.0) ? amp : -amp) : 0;
                m.pending = 1'b1;
                m.zs = z;
            end
        end
        m.cnt = (m.cnt + 1) % (bps * CPB);
        return m;
    endfunction

    // Advance the reference model on the same edges as the DUTs.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mdl[d] <= '{default: 0};
            end else begin
                mdl[d] <= model_step(mdl[d], bps_of(d), amp_of(d), en, din, diff_en, zero_stuff);
            end
        end
    end

    task automatic compare(input string name, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic read_dut(input int d, output int o_di, output int o_dq,
                            output int o_ss, output int o_bs);
        case (d)
            0:       begin o_di = int'(di_a); o_dq = int'(dq_a); o_ss = int'(ss_a); o_bs = int'(bs_a); end
            1:       begin o_di = int'(di_b); o_dq = int'(dq_b); o_ss = int'(ss_b); o_bs = int'(bs_b); end
            default: begin o_di = int'(di_c); o_dq = int'(dq_c); o_ss = int'(ss_c); o_bs = int'(bs_c); end
        endcase
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        int a_di, a_dq, a_ss, a_bs;
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                read_dut(d, a_di, a_dq, a_ss, a_bs);
                compare("model_di", d, a_di, mdl[d].di);
                compare("model_dq", d, a_dq, mdl[d].dq);
                compare("model_sym_strobe", d, a_ss, int'(mdl[d].ss));
                compare("model_bit_strobe", d, a_bs,
                        int'(en && !rst && (mdl[d].cnt % CPB == 0)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input int d, input string name, input int e_di,
                               input int e_dq, input int e_ss);
        int a_di, a_dq, a_ss, a_bs;
        read_dut(d, a_di, a_dq, a_ss, a_bs);
        compare({name, "_di"}, d, a_di, e_di);
        compare({name, "_dq"}, d, a_dq, e_dq);
        compare({name, "_sym_strobe"}, d, a_ss, e_ss);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        en = 1'b1;
    endtask

    // Drive one symbol aligned to the symbol boundary and check the value it
    // produces. Optionally stall en for 5 cycles before cycle stall_at.
    task automatic applyStimulus(input vec_t v, input int stall_at,
                                 input int hold_di, input int hold_dq);
        int bps;
        int s;
        int a_di, a_dq, a_ss, a_bs;
        bps = bps_of(v.dut);
        s = bps * CPB;
        for (int c = 0; c < s; c++) begin
            if (c == stall_at) begin
                en = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    checkOutput(v.dut, "stall", hold_di, hold_dq, 0);
                    read_dut(v.dut, a_di, a_dq, a_ss, a_bs);
                    compare("stall_bit_strobe", v.dut, a_bs, 0);
                end
                en = 1'b1;
            end
            din = v.bits[bps - 1 - c / CPB];
            diff_en = v.diff;
            zero_stuff = v.zs;
            step();
            if (c == s - CPB + 1) begin
                checkOutput(v.dut, "table", v.exp_di, v.exp_dq, 1);
            end
            if (v.zs && c == s - CPB + 2) begin
                checkOutput(v.dut, "zero_stuff", 0, 0, 0);
            end
        end
    endtask

    initial begin
        int a_di, a_dq, a_ss, a_bs;

        tbl[0]  = '{0, 2'b00, 1'b1, 1'b0,  1,  1};
        tbl[1]  = '{0, 2'b01, 1'b1, 1'b0, -1,  1};
        tbl[2]  = '{0, 2'b11, 1'b1, 1'b0,  1, -1};
        tbl[3]  = '{0, 2'b10, 1'b1, 1'b0, -1, -1};
        tbl[4]  = '{0, 2'b00, 1'b0, 1'b0,  1,  1};
        tbl[5]  = '{0, 2'b01, 1'b0, 1'b0, -1,  1};
        tbl[6]  = '{0, 2'b11, 1'b0, 1'b0, -1, -1};
        tbl[7]  = '{0, 2'b10, 1'b0, 1'b0,  1, -1};
        tbl[8]  = '{1, 2'b11, 1'b1, 1'b1, -3, -3};
        tbl[9]  = '{1, 2'b11, 1'b1, 1'b1,  3,  3};
        tbl[10] = '{1, 2'b11, 1'b1, 1'b1, -3, -3};
        tbl[11] = '{1, 2'b11, 1'b1, 1'b1,  3,  3};
        tbl[12] = '{2, 2'b01, 1'b1, 1'b0, -1,  0};
        tbl[13] = '{2, 2'b01, 1'b1, 1'b0,  1,  0};
        tbl[14] = '{2, 2'b00, 1'b1, 1'b0,  1,  0};
        tbl[15] = '{2, 2'b01, 1'b1, 1'b0, -1,  0};

        step();
        chk_on = 1'b1;

        $display("[TB] reset state");
        for (int d = 0; d < 3; d++) begin
            checkOutput(d, "reset_state", 0, 0, 0);
            read_dut(d, a_di, a_dq, a_ss, a_bs);
            compare("reset_bit_strobe", d, a_bs, 0);
        end

        $display("[TB] table vectors");
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                applyReset();
            end
            applyStimulus(tbl[i], -1, 0, 0);
        end

        $display("[TB] enable stall mid-symbol");
        applyReset();
        applyStimulus('{0, 2'b01, 1'b1, 1'b0, -1, 1}, -1, 0, 0);
        applyStimulus('{0, 2'b11, 1'b1, 1'b0, 1, -1}, 2, -1, 1);

        $display("[TB] reset mid-symbol");
        applyReset();
        applyStimulus('{0, 2'b01, 1'b1, 1'b0, -1, 1}, -1, 0, 0);
        din = 1'b1;
        step();
        rst = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            checkOutput(d, "mid_reset", 0, 0, 0);
            read_dut(d, a_di, a_dq, a_ss, a_bs);
            compare("mid_reset_bit_strobe", d, a_bs, 0);
        end
        rst = 1'b0;
        en = 1'b1;
        applyStimulus('{0, 2'b00, 1'b1, 1'b0, 1, 1}, -1, 0, 0);

        $display("[TB] randomized stream");
        applyReset();
        for (int n = 0; n < 2000; n++) begin
            din = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) diff_en = ~diff_en;
            if ($urandom_range(0, 15) == 0) zero_stuff = ~zero_stuff;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
